// File: rtl/typed_fifo_pkg.sv
// Shared types and sizing helpers for the typed tag FIFO and its users.
package typed_fifo_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic         tag_default_t;
    typedef logic [1:0]   pay2_t;
    typedef logic [9:0]   pay10_t;
    typedef enum pay10_t {A, B, C, D} op_e;

endpackage

// File: rtl/typed_fifo_ptr.sv
// Circular index register that advances on inc and wraps from DEPTH-1 to 0.
module typed_fifo_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc,
    output logic [$clog2(DEPTH)-1:0]   ptr
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/typed_tag_fifo.sv
// First-word-fall-through FIFO carrying a type-parameterised payload and tag,
// with occupancy, almost-full threshold and a sticky overflow flag.
module typed_tag_fifo
    import typed_fifo_pkg::*;
#(
    parameter type         T         = logic,
    parameter type         U         = tag_default_t,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  T                           in_data,
    input  U                           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output T                           out_data,
    output U                           out_tag,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       almost_full,
    output logic                       overflow_err
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    T mem  [DEPTH];
    U tmem [DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != CW'(0));
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    typed_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    typed_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; visibility is governed by count.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            mem[wr_ptr]  <= in_data;
            tmem[wr_ptr] <= in_tag;
        end
    end

    assign out_data     = out_valid ? mem[rd_ptr]  : T'(0);
    assign out_tag      = out_valid ? tmem[rd_ptr] : U'(0);
    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_typed_tag_fifo.sv
// Directed bench for typed_tag_fifo across several parameterisations.
module tb_typed_tag_fifo;
    import typed_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u0: all defaults
    logic u0_iv = 0, u0_ir, u0_ov, u0_or = 0, u0_af, u0_oe;
    logic u0_id = 0, u0_it = 0, u0_od, u0_ot;
    logic [2:0] u0_cnt;
    typed_tag_fifo u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(u0_iv), .in_ready(u0_ir),
        .in_data(u0_id), .in_tag(u0_it), .out_valid(u0_ov), .out_ready(u0_or),
        .out_data(u0_od), .out_tag(u0_ot), .count(u0_cnt),
        .almost_full(u0_af), .overflow_err(u0_oe));

    // u1: positional overrides, DEPTH=3
    logic u1_iv = 0, u1_ir, u1_ov, u1_or = 0, u1_af, u1_oe;
    logic [1:0] u1_id = 0, u1_od;
    logic [2:0] u1_it = 0, u1_ot;
    logic [1:0] u1_cnt;
    typed_tag_fifo #(logic [1:0], logic [2:0], 3) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u1_iv), .in_ready(u1_ir),
        .in_data(u1_id), .in_tag(u1_it), .out_valid(u1_ov), .out_ready(u1_or),
        .out_data(u1_od), .out_tag(u1_ot), .count(u1_cnt),
        .almost_full(u1_af), .overflow_err(u1_oe));

    // u2: enum tag only
    logic u2_iv = 0, u2_ir, u2_ov, u2_or = 0, u2_af, u2_oe;
    logic u2_id = 0, u2_od;
    op_e  u2_it = A, u2_ot;
    logic [2:0] u2_cnt;
    typed_tag_fifo #(.U(op_e)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(u2_iv), .in_ready(u2_ir),
        .in_data(u2_id), .in_tag(u2_it), .out_valid(u2_ov), .out_ready(u2_or),
        .out_data(u2_od), .out_tag(u2_ot), .count(u2_cnt),
        .almost_full(u2_af), .overflow_err(u2_oe));

    // u3: DEPTH=4, AFULL_LVL=2, byte payload
    logic u3_iv = 0, u3_ir, u3_ov, u3_or = 0, u3_af, u3_oe;
    logic [7:0] u3_id = 0, u3_od;
    logic [3:0] u3_it = 0, u3_ot;
    logic [2:0] u3_cnt;
    typed_tag_fifo #(.T(logic [7:0]), .U(logic [3:0]), .DEPTH(4), .AFULL_LVL(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(u3_iv), .in_ready(u3_ir),
        .in_data(u3_id), .in_tag(u3_it), .out_valid(u3_ov), .out_ready(u3_or),
        .out_data(u3_od), .out_tag(u3_ot), .count(u3_cnt),
        .almost_full(u3_af), .overflow_err(u3_oe));

    typedef struct {
        logic       iv;
        logic       d;
        logic       t;
        logic       ordy;
        logic [2:0] cnt;
        logic       ov;
        logic       od;
        logic       ot;
        logic       ir;
        logic       af;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1 vectors: push 4 then pop 4 on defaults instance
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        #2;
        chk("rst_cnt", 32'(u0_cnt), 32'd0);
        chk("rst_ov",  32'(u0_ov),  32'd0);
        chk("rst_ir",  32'(u0_ir),  32'd1);
        chk("rst_af",  32'(u0_af),  32'd0);
        chk("rst_oe",  32'(u0_oe),  32'd0);
        chk("rst_od",  32'(u0_od),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 8; k++) begin
            u0_iv = tv[k].iv; u0_id = tv[k].d; u0_it = tv[k].t; u0_or = tv[k].ordy;
            step();
            chk($sformatf("t1_cnt[%0d]", k), 32'(u0_cnt), 32'(tv[k].cnt));
            chk($sformatf("t1_ov[%0d]", k),  32'(u0_ov),  32'(tv[k].ov));
            chk($sformatf("t1_od[%0d]", k),  32'(u0_od),  32'(tv[k].od));
            chk($sformatf("t1_ot[%0d]", k),  32'(u0_ot),  32'(tv[k].ot));
            chk($sformatf("t1_ir[%0d]", k),  32'(u0_ir),  32'(tv[k].ir));
            chk($sformatf("t1_af[%0d]", k),  32'(u0_af),  32'(tv[k].af));
        end
        u0_or = 1'b0;

        // Test 2: streaming through DEPTH=3, pointers wrap repeatedly
        for (int i = 0; i < 10; i++) begin
            if (i > 0) chk($sformatf("t2_pre_od[%0d]", i), 32'(u1_od), 32'((i - 1) % 4));
            u1_iv = 1'b1; u1_or = 1'b1;
            u1_id = 2'(i % 4); u1_it = 3'(i % 8);
            step();
            chk($sformatf("t2_cnt[%0d]", i), 32'(u1_cnt), 32'd1);
            chk($sformatf("t2_od[%0d]", i),  32'(u1_od),  32'(i % 4));
            chk($sformatf("t2_ot[%0d]", i),  32'(u1_ot),  32'(i % 8));
        end
        u1_iv = 1'b0;
        step();
        chk("t2_cnt_end", 32'(u1_cnt), 32'd0);
        chk("t2_ov_end",  32'(u1_ov),  32'd0);
        u1_or = 1'b0;

        // Test 3: enum tag round-trip
        for (int i = 0; i < 4; i++) begin
            u2_iv = 1'b1; u2_id = 1'(i); u2_it = op_e'(pay10_t'(i));
            step();
        end
        u2_iv = 1'b0;
        chk("t3_cnt", 32'(u2_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_tag[%0d]", i), 32'(u2_ot), 32'(i));
            chk($sformatf("t3_dat[%0d]", i), 32'(u2_od), 32'(i % 2));
            u2_or = 1'b1;
            step();
        end
        u2_or = 1'b0;
        chk("t3_empty", 32'(u2_ov), 32'd0);

        // Test 4: full with simultaneous offer and pop
        for (int i = 0; i < 4; i++) begin
            u3_iv = 1'b1; u3_id = 8'(8'h10 + i); u3_it = 4'(i);
            step();
            chk($sformatf("t4_af[%0d]", i), 32'(u3_af), (i >= 1) ? 32'd1 : 32'd0);
        end
        chk("t4_ir_full", 32'(u3_ir), 32'd0);
        u3_iv = 1'b1; u3_or = 1'b1; u3_id = 8'hEE; u3_it = 4'hE;
        step();
        chk("t4_cnt",  32'(u3_cnt), 32'd3);
        chk("t4_oe",   32'(u3_oe),  32'd1);
        chk("t4_head", 32'(u3_od),  32'h11);
        u3_iv = 1'b0; u3_or = 1'b0;
        step();
        chk("t4_oe_sticky", 32'(u3_oe), 32'd1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t4_drain[%0d]", i), 32'(u3_od), 32'(8'h10 + i));
            u3_or = 1'b1;
            step();
        end
        u3_or = 1'b0;
        chk("t4_drained", 32'(u3_cnt), 32'd0);

        // Test 5: empty with push and pop both requested
        u3_iv = 1'b1; u3_or = 1'b1; u3_id = 8'hA5; u3_it = 4'h5;
        #1;
        chk("t5_ov_before", 32'(u3_ov), 32'd0);
        step();
        chk("t5_ov_after", 32'(u3_ov), 32'd1);
        chk("t5_cnt",      32'(u3_cnt), 32'd1);
        chk("t5_od",       32'(u3_od),  32'hA5);

        // Test 6: asynchronous reset mid-cycle with two entries held
        u3_or = 1'b0; u3_id = 8'h3C;
        step();
        u3_iv = 1'b0;
        chk("t6_cnt_pre", 32'(u3_cnt), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_cnt_rst", 32'(u3_cnt), 32'd0);
        chk("t6_ov_rst",  32'(u3_ov),  32'd0);
        chk("t6_oe_rst",  32'(u3_oe),  32'd0);
        chk("t6_od_rst",  32'(u3_od),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        u3_iv = 1'b1; u3_id = 8'h5A; u3_it = 4'h9;
        step();
        u3_iv = 1'b0;
        chk("t6_cnt_post", 32'(u3_cnt), 32'd1);
        chk("t6_od_post",  32'(u3_od),  32'h5A);
        chk("t6_ot_post",  32'(u3_ot),  32'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/typed_tag_fifo.md
Name: typed_tag_fifo

Overview:
- Synchronous FIFO whose payload and sideband tag are type parameters (`T`, `U`), both defaulting to `logic`.
- Successor to the single-register typed-parameter modules: adds depth, a valid/ready handshake on both sides, occupancy reporting and an almost-full threshold.
- Sits between producer and consumer stages that exchange arbitrary packed types: vectors, enums, packed structs.
- Must elaborate cleanly under the type-parameter conversion flow, with positional, named, partial-named and default parameter overrides.

Parameters:
- `T`, `logic`: payload type; any packed type; data width = `$bits(T)`.
- `U`, `logic`: tag type; any packed type; tag width = `$bits(U)`.
- `DEPTH`, 4: number of entries; legal range 2..256; need not be a power of two.
- `AFULL_LVL`, `DEPTH-1`: `almost_full` asserts when count >= `AFULL_LVL`; legal range 1..`DEPTH`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  producer presents an entry.
- `in_ready`  out  1  FIFO can accept an entry.
- `in_data`  in  `$bits(T)` (type `T`)  payload.
- `in_tag`  in  `$bits(U)` (type `U`)  tag.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  `$bits(T)` (type `T`)  head payload.
- `out_tag`  out  `$bits(U)` (type `U`)  head tag.
- `count`  out  `$clog2(DEPTH+1)`  current occupancy.
- `almost_full`  out  1  count >= `AFULL_LVL`.
- `overflow_err`  out  1  sticky; set when `in_valid` is high while `in_ready` is low.

Behaviour:
- Reset (`rst_n` low, asynchronous assert, synchronous release): `rd_ptr`=0, `wr_ptr`=0, `count`=0, `out_valid`=0, `in_ready`=1, `almost_full`=0, `overflow_err`=0.
- Storage array is not reset.
- Reset asserted mid-operation discards all entries immediately. No partial transfer completes on that edge.
- Handshake definitions:
  - push = `in_valid` && `in_ready`
  - pop = `out_valid` && `out_ready`
  - A transfer happens on the rising edge where the condition holds.
- `in_ready` = (count != `DEPTH`). It is a function of registered state only, never of `out_ready`. A full FIFO therefore refuses a push even when a pop happens in the same cycle.
- `out_valid` = (count != 0). Read is first-word-fall-through: `out_data`/`out_tag` drive `mem[rd_ptr]` combinationally.
- When `out_valid`=0, `out_data` = `T'(0)` and `out_tag` = `U'(0)`. These are forced zeros, not stale storage.
- Latency: an entry pushed into an empty FIFO at edge N appears on the outputs after edge N. There is no same-cycle bypass.
- Pointer update: each pointer advances by 1 on its event and wraps from `DEPTH-1` to 0 by explicit compare. No power-of-two masking.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
  - This case is legal whenever 0 < count < `DEPTH`.
- Empty with `in_valid`=1 and `out_ready`=1: push only; count 0 -> 1.
- `almost_full` is combinational from `count`. With `AFULL_LVL`=`DEPTH` it equals !`in_ready`.
- `overflow_err` sets on any edge with `in_valid`=1 and `in_ready`=0, and clears only on reset. The offered entry is dropped, with no state change.
- Arithmetic on `T`/`U` is width-exact. Values are stored and returned bit-for-bit; enums round-trip unchanged.

Decomposition:
- Shared package `typed_fifo_pkg` holds:
  - `localparam` helper function `cnt_w(depth)` returning `$clog2(depth+1)`.
  - Default tag typedef `tag_default_t` = `logic`.
  - Test typedefs: `pay2_t` = `logic [1:0]`, `pay10_t` = `logic [9:0]`, enum `op_e` of `pay10_t` {A, B, C, D}.
- One sub-module, `typed_fifo_ptr`: parameter `DEPTH`; inputs `clk`, `rst_n`, `inc`; output `ptr` wrapping at `DEPTH`. Instantiated twice, for read and write.
- Storage stays in the top module as `T mem[DEPTH]` and `U tmem[DEPTH]`.

Test Plan:
1. Defaults, `T`=`logic`, `U`=`logic`, `DEPTH`=4. Push (1,0), (0,1), (1,1), (0,0) with `out_ready`=0 -> `count` = 1, 2, 3, 4; `almost_full` rises at count 3; `in_ready`=0 at 4. Then pop 4 -> same order out; `out_data` = 0 after empty.
2. `T`=`logic [1:0]` positional, `U`=`logic [2:0]`, `DEPTH`=3. Continuous push and pop for 10 entries, data = i mod 4, tag = i mod 8 -> outputs match in order; pointers wrap 2 -> 0 with no loss; `count` stays 1 throughout steady state.
3. Named override `.U(op_e)` only, `T` defaulted. Push tags A, B, C, D -> popped tags A, B, C, D with enum values 0, 1, 2, 3; `$bits(out_tag)`=10.
4. Full plus simultaneous push and pop (`DEPTH`=4, `AFULL_LVL`=2): fill to 4, then `in_valid`=1 and `out_ready`=1 -> pop accepted, push refused, `count`=3, `overflow_err`=1 and stays 1.
5. Empty, `in_valid`=1, `out_ready`=1 at edge N -> `out_valid`=0 before N, 1 after N; `count`=1.
6. Assert `rst_n`=0 asynchronously mid-cycle with `count`=2 -> `count`=0, `out_valid`=0, `overflow_err`=0 immediately, without waiting for a clock edge. After release, the first push returns its own data, not stale data.
